div_iter: RTL
=============

Name: div_iter

Overview:
- Iterative radix-2 restoring divider in the execute stage; services DIV/DIVU and writes HI = remainder, LO = quotient.
- Generates `div_block`, which the hazard unit uses to drive `es_stall` and to hold fetch, decode and execute.
- Consumes the execute-stage flush so that an exception, ERET or branch mispredict aborts a division in flight.

Parameters:
- WIDTH, 32, operand, quotient and remainder width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  pipeline clock.
- resetn  in  1  asynchronous active-low reset.
- div_req  in  1  execute stage holds a valid, unflushed DIV/DIVU; stays high until `div_done`.
- div_signed  in  1  1 = DIV (signed), 0 = DIVU; sampled on accept.
- div_x  in  WIDTH  dividend (rs); sampled on accept.
- div_y  in  WIDTH  divisor (rt); sampled on accept.
- es_flush  in  1  execute-stage flush (exception, ERET or mispredict); aborts the operation.
- div_block  out  1  stall request to the hazard unit.
- div_done  out  1  one-cycle pulse; `div_q`/`div_r` valid this cycle.
- div_q  out  WIDTH  quotient, toward LO.
- div_r  out  WIDTH  remainder, toward HI.

Behaviour:
- Reset (resetn low, asynchronous): state IDLE, counter 0, `div_done` 0, `div_q`/`div_r` 0, `div_block` 0.
- State IDLE:
  - Accept when `div_req & ~es_flush`.
  - Latch `|x|` and `|y|` (magnitudes only when `div_signed`), `sign_q = x[W-1]^y[W-1]`, `sign_r = x[W-1]`, and a y==0 flag.
  - Clear the partial remainder; set counter = WIDTH; go to CALC.
- State CALC, one bit per cycle:
  - Shift {rem, dividend} left by 1.
  - Trial-subtract |y| on WIDTH+1 bits.
  - If non-negative, keep the difference and set quotient bit = 1; otherwise restore and set the bit to 0.
  - Decrement the counter; when the counter reaches 1, go to DONE.
- State DONE:
  - `div_done` = 1 for this single cycle.
  - `div_q`/`div_r` are registered; they are sign-corrected (quotient negated if `sign_q`, remainder negated if `sign_r`) only for signed operations.
  - Go to IDLE next cycle unconditionally.
- Latency: request accepted in cycle 0; CALC spans cycles 1..WIDTH; DONE in cycle WIDTH+1 (33 for WIDTH=32).
- div_block is combinational: `div_req & ~div_done & ~es_flush`.
  - High from cycle 0 through WIDTH, low in the DONE cycle, so the instruction advances with the result.
- Divide by zero (y==0), signed or unsigned: `div_q` = all ones, `div_r` = div_x unmodified; sign correction is suppressed.
- Signed overflow (0x80000000 / -1): `div_q` = 0x80000000, `div_r` = 0; no trap.
- es_flush in CALC or DONE: go to IDLE next cycle, `div_done` forced 0 in that cycle, and no result is produced.
- es_flush and div_req together in IDLE: no accept.
- div_req dropping in CALC without es_flush is illegal; the design treats it as an abort identical to es_flush.
- Back-to-back divisions: a new accept is possible in the IDLE cycle immediately after DONE.
- `div_q`/`div_r` hold their last value between operations.

Optional Feature:
- Macro: `DIV_ZERO_FAST_EN`.
- Defined: when the y==0 flag is set at accept, skip CALC and go IDLE -> DONE; result in cycle 1, `div_block` high for 1 cycle only.
- Undefined: divide-by-zero takes the full WIDTH+1 latency with the same result values.

Decomposition:
- Shared package `div_pkg`: state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and the DIV_LAT = WIDTH+1 constant used by the bench.
- No sub-module: the datapath (shift/subtract, two-sided negation) and the FSM stay in `div_iter`, targeting ~150-200 lines.

Test Plan:
- Unsigned: DIVU 100 / 7 -> `div_done` exactly at cycle 33, q=14, r=2; `div_block` high cycles 0..32, low at 33.
- Signed: DIV -7 / 2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1); DIV 7 / -2 -> q=-3, r=1.
- Edge values:
  - DIV 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0.
  - DIVU 0xFFFFFFFF / 1 -> q=0xFFFFFFFF, r=0.
- Zero divisor: DIV 0x12345678 / 0 -> q=0xFFFFFFFF, r=0x12345678 at cycle 33; with `DIV_ZERO_FAST_EN`, at cycle 1.
- Flush mid-operation: es_flush at cycle 10 -> `div_block` low in cycle 10, no `div_done`, IDLE in cycle 11; a new DIVU 9 / 3 accepted in cycle 11 gives q=3, r=0 at cycle 44.
- Reset: resetn low at cycle 20 of a division -> all outputs 0 immediately (asynchronous); after release, IDLE with no spurious `div_done`.

Source files
------------

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div_pkg
//  Brief    : Shared constants for the iterative divider: FSM state encoding
//             and the nominal request-to-result latency.
//  Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

    // Nominal operand width and the accept-to-done latency in cycles
    localparam int DIV_WIDTH = 32;
    localparam int DIV_LAT   = DIV_WIDTH + 1;

    // Divider FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
//  Module   : div_iter
//  Brief    : Iterative radix-2 restoring divider for DIV/DIVU in the execute
//             stage. Produces quotient (LO) and remainder (HI), a stall
//             request for the hazard unit, and honours execute-stage flush.
//             Optional macro DIV_ZERO_FAST_EN: a zero divisor bypasses the
//             iteration and completes one cycle after accept.
//  Revision : 1.0 - initial release
// ============================================================================
module div_iter
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_req,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] div_x,
    input  logic [WIDTH-1:0] div_y,
    input  logic             es_flush,
    output logic             div_block,
    output logic             div_done,
    output logic [WIDTH-1:0] div_q,
    output logic [WIDTH-1:0] div_r
);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;      // partial remainder
    logic [WIDTH-1:0] r_quo;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] r_y;        // divisor magnitude
    logic [WIDTH-1:0] r_x_raw;    // original dividend, returned on divide-by-zero
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_y_zero;
    logic             r_done;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;

    logic             w_accept;
    logic             w_abort;
    logic             w_y_zero;
    logic [WIDTH-1:0] w_x_abs;
    logic [WIDTH-1:0] w_y_abs;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_bit;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    // Operand conditioning at accept: magnitudes only for signed operations
    assign w_accept = div_req & ~es_flush;
    assign w_abort  = es_flush | ~div_req;
    assign w_y_zero = (div_y == '0);
    assign w_x_abs  = (div_signed & div_x[WIDTH-1]) ? -div_x : div_x;
    assign w_y_abs  = (div_signed & div_y[WIDTH-1]) ? -div_y : div_y;

    // One restoring step: shift {rem, dividend} left, trial-subtract on WIDTH+1 bits
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, r_y};
    assign w_bit     = ~w_diff[WIDTH];
    assign w_rem_nxt = w_bit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_bit};

    // Final sign correction; a zero divisor overrides it with the fixed result
    assign w_q_fix = r_y_zero ? '1      : (r_sign_q ? -w_quo_nxt : w_quo_nxt);
    assign w_r_fix = r_y_zero ? r_x_raw : (r_sign_r ? -w_rem_nxt : w_rem_nxt);

    // Divider FSM and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_y      <= '0;
            r_x_raw  <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_y_zero <= 1'b0;
            r_done   <= 1'b0;
            r_q      <= '0;
            r_r      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_rem    <= '0;
                        r_quo    <= w_x_abs;
                        r_y      <= w_y_abs;
                        r_x_raw  <= div_x;
                        r_sign_q <= div_signed & (div_x[WIDTH-1] ^ div_y[WIDTH-1]);
                        r_sign_r <= div_signed & div_x[WIDTH-1];
                        r_y_zero <= w_y_zero;
                        r_cnt    <= CNT_W'(WIDTH);
`ifdef DIV_ZERO_FAST_EN
                        if (w_y_zero) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_q     <= '1;
                            r_r     <= div_x;
                        end else begin
                            r_state <= ST_CALC;
                        end
`else
                        r_state  <= ST_CALC;
`endif
                    end
                end
                ST_CALC: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_q     <= w_q_fix;
                            r_r     <= w_r_fix;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // A flush in the completion cycle suppresses the done pulse; the stall
    // drops in the done cycle so the instruction advances with its result
    assign div_done  = r_done & ~es_flush;
    assign div_block = resetn & div_req & ~div_done & ~es_flush;
    assign div_q     = r_q;
    assign div_r     = r_r;

endmodule
`default_nettype wire
